// File: rtl/memoria_programa_dp.sv
// Dual-port program memory: port A loader/debug (byte writes), port B fetch,
// plus a sweep engine that zeroes the whole array on request.
module memoria_programa_dp #(
    parameter int    RAM_WIDTH    = 32,
    parameter int    BYTE_WIDTH   = 8,
    parameter int    RAM_DEPTH    = 2048,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "",
    localparam int   NB_BYTES     = RAM_WIDTH / BYTE_WIDTH,
    localparam int   ADDR_WIDTH   = $clog2(RAM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  soft_reset,
    input  logic                  i_clear_req,
    input  logic                  i_a_en,
    input  logic [NB_BYTES-1:0]   i_a_we,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [RAM_WIDTH-1:0]  i_a_data,
    output logic [RAM_WIDTH-1:0]  o_a_data,
    input  logic                  i_b_en,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    output logic [RAM_WIDTH-1:0]  o_b_data,
    output logic                  o_b_valid,
    output logic                  o_busy,
    output logic                  o_clear_done,
    output logic [ADDR_WIDTH-1:0] o_clear_addr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [RAM_WIDTH-1:0]  mem [RAM_DEPTH];
    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  busy;
    logic                  a_rd;
    logic                  a_wr;
    logic                  b_rd;
    logic                  clr_we;
    logic [RAM_WIDTH-1:0]  a_q;
    logic [RAM_WIDTH-1:0]  b_q;
    logic                  b_v;

    assign busy   = (state != ST_IDLE);
    assign a_rd   = i_a_en && (i_a_we == '0) && !busy;
    assign a_wr   = i_a_en && (i_a_we != '0) && !busy;
    assign b_rd   = i_b_en && !busy;
    assign clr_we = (state == ST_CLEAR);

    always_ff @(posedge i_clk or negedge soft_reset) begin
        if (!soft_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_clear_req) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == LAST) state <= ST_DONE;
                    else             cnt   <= cnt + ADDR_WIDTH'(1);
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Array has no reset; the sweep and port A never collide since A is
    // blocked while busy.
    always_ff @(posedge i_clk) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end else if (a_wr) begin
            for (int k = 0; k < NB_BYTES; k++) begin
                if (i_a_we[k])
                    mem[i_a_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <=
                        i_a_data[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // First read stage: read-first, so a same-cycle write is not seen.
    always_ff @(posedge i_clk or negedge soft_reset) begin
        if (!soft_reset) begin
            a_q <= '0;
            b_q <= '0;
            b_v <= 1'b0;
        end else begin
            b_v <= b_rd;
            if (a_rd) a_q <= mem[i_a_addr];
            if (b_rd) b_q <= mem[i_b_addr];
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                 a_v;
            logic                 b_v2;
            logic [RAM_WIDTH-1:0] a_q2;
            logic [RAM_WIDTH-1:0] b_q2;

            always_ff @(posedge i_clk or negedge soft_reset) begin
                if (!soft_reset) begin
                    a_v  <= 1'b0;
                    b_v2 <= 1'b0;
                    a_q2 <= '0;
                    b_q2 <= '0;
                end else begin
                    a_v  <= a_rd;
                    b_v2 <= b_v;
                    if (a_v) a_q2 <= a_q;
                    if (b_v) b_q2 <= b_q;
                end
            end

            assign o_a_data  = a_q2;
            assign o_b_data  = b_q2;
            assign o_b_valid = b_v2;
        end else begin : g_lat1
            assign o_a_data  = a_q;
            assign o_b_data  = b_q;
            assign o_b_valid = b_v;
        end
    endgenerate

    assign o_busy       = busy;
    assign o_clear_done = (state == ST_DONE);
    assign o_clear_addr = cnt;

endmodule
